// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared UART constants and receiver state encoding.
// Rev 1.0 - initial release.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 103;
    localparam int UART_DATA_BITS            = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// uart_rx_sync: two-flop synchroniser for asynchronous inputs, resets to 1 (idle line).
// Rev 1.0 - initial release.
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx: 8N1 UART receiver with mid-bit sampling and a VALID/READY holding register.
// Rev 1.0 - initial release.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Loads are one less than the interval because the counter fires on reaching zero.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rx_s;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    uart_rx_sync u_sync (
        .clk      (CLK),
        .resetn   (RESETN),
        .async_in (RX),
        .sync_out (rx_s)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= RX_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            if (VALID && READY) begin
                VALID <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state    <= RX_START;
                        baud_cnt <= HALF_LOAD;
                    end
                end

                RX_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LOAD;
                        bit_idx  <= '0;
                        state    <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                RX_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BIT_LOAD;
                        shift    <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                RX_STOP: begin
                    if (baud_cnt == '0) begin
                        if (rx_s) begin
                            state <= RX_IDLE;
                            // A same-cycle handshake frees the register, so the new byte lands.
                            if (VALID && !READY) begin
                                OVERRUN <= 1'b1;
                            end else begin
                                DATA  <= shift;
                                VALID <= 1'b1;
                            end
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx: drives serial frames into uart_rx and compares timed output events
// against a frame-level reference model.
module tb_uart_rx;

    localparam int CPB  = 103;
    localparam int HALF = CPB / 2;

    localparam int EV_ACCEPT  = 1;
    localparam int EV_FERR    = 2;
    localparam int EV_OVERRUN = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       RX = 1'b1;
    logic       READY = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .RX        (RX),
        .DATA      (DATA),
        .VALID     (VALID),
        .READY     (READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // A handshake event is logged on the cycle both VALID and READY are seen high.
    always @(negedge CLK) begin
        if (RESETN) begin
            if (VALID && READY) obs_q.push_back('{cyc, EV_ACCEPT, DATA});
            if (FRAME_ERR)      obs_q.push_back('{cyc, EV_FERR, 8'h00});
            if (OVERRUN)        obs_q.push_back('{cyc, EV_OVERRUN, 8'h00});
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line driven low just after edge n: two sync stages plus one FSM edge give t0 = n+3.
    function automatic int done_cyc(input int n);
        return n + 3 + HALF + 9 * CPB;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        start_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            RX = f[i];
            if (i == 0) start_cyc = cyc;
            repeat (CPB - 1) @(posedge CLK);
        end
    endtask

    task automatic idle_line(input int g);
        if (g > 0) begin
            @(posedge CLK); #1;
            RX = 1'b1;
            repeat (g - 1) @(posedge CLK);
        end
    endtask

    task automatic glitch(input int len);
        @(posedge CLK); #1;
        RX = 1'b0;
        repeat (len - 1) @(posedge CLK);
        idle_line(HALF + 5);
    endtask

    task automatic expect_good(input int n, input logic [7:0] b);
        exp_q.push_back('{done_cyc(n), EV_ACCEPT, b});
    endtask

    task automatic expect_bad(input int n);
        exp_q.push_back('{done_cyc(n), EV_FERR, 8'h00});
    endtask

    task automatic compare_events(input string tag);
        int m;
        repeat (8) @(posedge CLK);
        check_value($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check_value($sformatf("%s_ev%0d_cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
            check_value($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
            check_value($sformatf("%s_ev%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic drain_one(input logic [7:0] b);
        @(posedge CLK); #1;
        READY = 1'b1;
        exp_q.push_back('{cyc, EV_ACCEPT, b});
        @(posedge CLK); #1;
        READY = 1'b0;
    endtask

    initial begin
        int n, n1, n2, c2, kind, len;
        logic [7:0] b;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check_value("reset_valid", VALID, 1'b0);
        check_value("reset_data", DATA, 8'h00);
        check_value("reset_ferr", FRAME_ERR, 1'b0);
        check_value("reset_overrun", OVERRUN, 1'b0);
        @(posedge CLK); #1;
        RESETN = 1'b1;
        idle_line(10);

        send_frame(8'h48, 1'b1, n);
        expect_good(n, 8'h48);
        idle_line(5);
        compare_events("single");

        for (int i = 0; i < 5; i++) begin
            send_frame(hello[i], 1'b1, n);
            expect_good(n, hello[i]);
        end
        compare_events("hello");

        glitch(20);
        send_frame(8'h55, 1'b1, n);
        expect_good(n, 8'h55);
        compare_events("glitch");

        send_frame(8'hA5, 1'b0, n);
        expect_bad(n);
        repeat (2000) @(posedge CLK);
        idle_line(20);
        send_frame(8'h3C, 1'b1, n);
        expect_good(n, 8'h3C);
        compare_events("break");

        READY = 1'b0;
        send_frame(8'h11, 1'b1, n1);
        send_frame(8'h22, 1'b1, n2);
        exp_q.push_back('{done_cyc(n2), EV_OVERRUN, 8'h00});
        @(negedge CLK);
        check_value("overrun_data_held", DATA, 8'h11);
        check_value("overrun_valid_held", VALID, 1'b1);
        drain_one(8'h11);
        @(negedge CLK);
        check_value("overrun_drained", VALID, 1'b0);
        compare_events("overrun");

        send_frame(8'h11, 1'b1, n1);
        c2 = done_cyc(n1 + 10 * CPB);
        fork
            send_frame(8'h22, 1'b1, n2);
            begin
                do begin
                    @(posedge CLK); #1;
                end while (cyc < c2 - 1);
                READY = 1'b1;
                @(posedge CLK); #1;
                READY = 1'b0;
            end
        join
        exp_q.push_back('{c2 - 1, EV_ACCEPT, 8'h11});
        @(negedge CLK);
        check_value("simul_data", DATA, 8'h22);
        check_value("simul_valid", VALID, 1'b1);
        drain_one(8'h22);
        compare_events("simul");
        READY = 1'b1;

        fork
            send_frame(8'hF0, 1'b1, n);
            begin
                repeat (5 * CPB + 50) @(posedge CLK);
                #1 RESETN = 1'b0;
                @(negedge CLK);
                check_value("midreset_valid", VALID, 1'b0);
                @(posedge CLK); #1;
                RESETN = 1'b1;
            end
        join
        idle_line(5);
        send_frame(8'h0F, 1'b1, n);
        expect_good(n, 8'h0F);
        compare_events("midreset");

        for (int k = 0; k < 10; k++) begin
            kind = $urandom_range(0, 9);
            b    = 8'($urandom_range(0, 255));
            if (kind < 2) begin
                len = $urandom_range(1, 40);
                glitch(len);
            end else if (kind < 4) begin
                send_frame(b, 1'b0, n);
                expect_bad(n);
                idle_line($urandom_range(1, 40));
            end else begin
                send_frame(b, 1'b1, n);
                expect_good(n, b);
                idle_line($urandom_range(0, 30));
            end
        end
        compare_events("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
